data_receiver: RTL and testbench
================================

// Module: data_receiver
// PURPOSE
//  Clock-domain-B end of the 4-phase req/ack multi-bit CDC handshake.
//  Synchronises the asynchronous request, captures the quasi-static data bus and returns an acknowledge.
//  Delivers each word as a one-cycle valid pulse to local logic.
//  Checks that consecutive words increment by 1 (modulo 2^DATA_W) and counts violations.
// PARAMETERS
//  DATA_W      4  width of the transferred data word
//  SYNC_STAGES 2  flops in the i_data_req synchroniser (legal >= 2)
//  ACK_DELAY   0  extra clk_b cycles between capture and o_data_ack rising (0..255)
//  CHECK_SEQ   1  1 = enable increment-sequence checker; 0 = o_seq_err/o_err_cnt tied 0
// PORTS
//  i_clk_b     in   1       clock domain B; single clock for the whole block
//  i_rst       in   1       synchronous, active-high reset
//  i_data_req  in   1       request from domain A (asynchronous to i_clk_b)
//  i_data      in   DATA_W  data from domain A; stable while i_data_req high
//  o_data_ack  out  1       acknowledge to domain A (registered)
//  o_data      out  DATA_W  captured word; holds until next capture
//  o_data_vld  out  1       1-cycle pulse, o_data updated this cycle
//  o_seq_err   out  1       1-cycle pulse with o_data_vld when word != expected
//  o_err_cnt   out  8       saturating count of sequence errors
//  o_busy      out  1       1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, synchroniser flops 0, FSM IDLE, expected-value register 0, first-word flag cleared.
//  Sync: req_s = last stage of SYNC_STAGES flop chain on i_data_req. No other signal is used raw except i_data.
//  i_data is sampled only in CAPTURE. It is stable because req_s lags i_data_req by >= SYNC_STAGES cycles.
//  FSM (one-hot or binary, registered):
//   IDLE    : req_s==1 (level, not edge) -> CAPTURE
//   CAPTURE : o_data<=i_data, o_data_vld=1 for this cycle.
//             Next state: ACK_DELAY==0 ? ACK : WAIT
//   WAIT    : counter counts ACK_DELAY cycles, then -> ACK
//   ACK     : o_data_ack=1. Stays in ACK while req_s==1; req_s==0 -> IDLE, o_data_ack=0 from next cycle
//  Latency (SYNC_STAGES=2, ACK_DELAY=0):
//   req sampled high at edge N -> req_s high after edge N+1 -> CAPTURE/vld in cycle after edge N+2
//   -> ack high after edge N+3
//   req low -> ack low SYNC_STAGES+1 edges later.
//  General latency: vld-to-ack = ACK_DELAY+1 cycles.
//  Level detect in IDLE: if req_s is already high again when ACK exits, a new capture starts after 1 IDLE cycle; no request is lost.
//  At most one capture per req high phase: ACK is left only on req_s==0.
//  Sequence checker (CHECK_SEQ=1), evaluated in CAPTURE:
//   - first word after reset: no error; exp <= i_data+1
//   - later words: i_data!=exp -> o_seq_err=1, o_err_cnt+1 (saturate at 8'hFF); exp <= i_data+1 always (resync)
//   - wrap: exp computed modulo 2^DATA_W, so F->0 (DATA_W=4) is legal, no error
//  Reset mid-operation (any state): next cycle all outputs 0 and FSM IDLE; in-flight word discarded.
//   If i_data_req is still high, it is recaptured after sync latency and treated as first word.
// TESTING
//  T1 reset: hold i_rst 3 cycles with req=1, data=4'hA -> ack/vld/data/err_cnt/busy all 0 during reset.
//   Then one capture of 4'hA, no seq_err.
//  T2 single transfer (defaults): data=4'h3, raise req -> vld pulse exactly once, o_data=4'h3 3 cycles after first sample edge.
//   ack high 1 cycle after vld; drop req -> ack low 3 cycles later.
//  T3 run 17 words 0..F,0 via full handshake -> 17 vld pulses, o_seq_err never 1, o_err_cnt=0.
//  T4 words 5,7,8 -> seq_err pulse only with 7; o_err_cnt=1; no error on 8.
//  T5 reset mid-transfer: assert i_rst while in ACK with req high -> ack 0 next cycle.
//   After release, one new capture of the held word, no seq_err.
//  T6 ACK_DELAY=3: ack rises 4 cycles after vld. 300 consecutive bad words -> o_err_cnt stops at 8'hFF.

Source files
------------

// File: rtl/data_receiver.sv
// Domain-B end of a 4-phase req/ack CDC handshake: synchronises req, captures the word, and returns ack.
// Capture happens SYNC_STAGES+1 edges after req is sampled, and ack follows ACK_DELAY+1 cycles later; the sender is throttled only by ack.
module data_receiver #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 0,
  parameter int CHECK_SEQ   = 1
) (
  input  logic              i_clk_b,
  input  logic              i_rst,
  input  logic              i_data_req,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ack,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_vld,
  output logic              o_seq_err,
  output logic [7:0]        o_err_cnt,
  output logic              o_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  localparam logic [7:0]        DLY_LAST = (ACK_DELAY == 0) ? 8'd0 : 8'(ACK_DELAY - 1);
  localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic [1:0]             state;
  logic [7:0]             dly_cnt;
  logic [DATA_W-1:0]      exp_data;
  logic                   seq_armed;

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk_b) begin
    if (i_rst) begin
      req_sync   <= '0;
      state      <= ST_IDLE;
      dly_cnt    <= 8'd0;
      exp_data   <= '0;
      seq_armed  <= 1'b0;
      o_data_ack <= 1'b0;
      o_data     <= '0;
      o_data_vld <= 1'b0;
      o_seq_err  <= 1'b0;
      o_err_cnt  <= 8'd0;
    end else begin
      req_sync   <= {req_sync[SYNC_STAGES-2:0], i_data_req};
      o_data_vld <= 1'b0;
      o_seq_err  <= 1'b0;
      case (state)
        // The word is latched on entry so o_data and o_data_vld line up in the CAPTURE cycle.
        ST_IDLE: begin
          if (req_s) begin
            state      <= ST_CAPTURE;
            o_data     <= i_data;
            o_data_vld <= 1'b1;
            if (CHECK_SEQ != 0) begin
              if (seq_armed && (i_data != exp_data)) begin
                o_seq_err <= 1'b1;
                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
              end
              exp_data  <= i_data + ONE;
              seq_armed <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (ACK_DELAY == 0) begin
            state      <= ST_ACK;
            o_data_ack <= 1'b1;
          end else begin
            state   <= ST_WAIT;
            dly_cnt <= 8'd0;
          end
        end
        ST_WAIT: begin
          if (dly_cnt == DLY_LAST) begin
            state      <= ST_ACK;
            o_data_ack <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 8'd1;
          end
        end
        ST_ACK: begin
          // Only a low synchronised req releases ACK, so one req phase yields one word.
          if (!req_s) begin
            state      <= ST_IDLE;
            o_data_ack <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver: one instance with default parameters, one with ACK_DELAY=3.
module tb_data_receiver;

  logic       clk;
  logic       rst  [2];
  logic       req  [2];
  logic [3:0] din  [2];
  logic       ack  [2];
  logic [3:0] dout [2];
  logic       vld  [2];
  logic       serr [2];
  logic [7:0] ecnt [2];
  logic       busy [2];

  int n_chk  = 0;
  int n_fail = 0;
  int vld_tot[2];
  int err_tot[2];

  data_receiver dut (
    .i_clk_b(clk), .i_rst(rst[0]), .i_data_req(req[0]), .i_data(din[0]),
    .o_data_ack(ack[0]), .o_data(dout[0]), .o_data_vld(vld[0]),
    .o_seq_err(serr[0]), .o_err_cnt(ecnt[0]), .o_busy(busy[0])
  );

  data_receiver #(.ACK_DELAY(3)) dut_d3 (
    .i_clk_b(clk), .i_rst(rst[1]), .i_data_req(req[1]), .i_data(din[1]),
    .o_data_ack(ack[1]), .o_data(dout[1]), .o_data_vld(vld[1]),
    .o_seq_err(serr[1]), .o_err_cnt(ecnt[1]), .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int d, input int n);
    rst[d] = 1'b1;
    repeat (n) tick();
    rst[d] = 1'b0;
  endtask

  // Full 4-phase handshake of one word, checking exactly one capture of the right value.
  task automatic xfer(input int d, input logic [3:0] w, input logic exp_err, input string tag);
    int nv;
    int t;
    logic err_seen;
    logic [3:0] got;
    nv = 0; err_seen = 1'b0; got = 4'h0;
    din[d] = w;
    req[d] = 1'b1;
    t = 0;
    while (!ack[d] && t < 40) begin
      tick(); t++;
      if (vld[d]) begin nv++; got = dout[d]; end
      if (serr[d]) err_seen = 1'b1;
    end
    chk({tag, "_ack_hi"}, 32'(ack[d]), 32'd1);
    req[d] = 1'b0;
    t = 0;
    while (ack[d] && t < 40) begin
      tick(); t++;
      if (vld[d]) nv++;
      if (serr[d]) err_seen = 1'b1;
    end
    chk({tag, "_ack_lo"}, 32'(ack[d]), 32'd0);
    chk({tag, "_nvld"}, 32'(nv), 32'd1);
    chk({tag, "_data"}, 32'(got), 32'(w));
    chk({tag, "_seqerr"}, 32'(err_seen), 32'(exp_err));
    vld_tot[d] += nv;
    if (err_seen) err_tot[d]++;
  endtask

  initial begin
    int t;
    logic [3:0] w;
    vld_tot[0] = 0; vld_tot[1] = 0; err_tot[0] = 0; err_tot[1] = 0;
    rst[0] = 1'b1; rst[1] = 1'b1;
    req[0] = 1'b1; req[1] = 1'b0;
    din[0] = 4'hA; din[1] = 4'h0;

    // T1: outputs held at zero through reset despite a high request
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_rst_outs", {ack[0], vld[0], dout[0], ecnt[0], busy[0]}, 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    xfer(0, 4'hA, 1'b0, "t1");

    // T2: exact edge timing, req raised just after an edge
    reset_dut(0, 2);
    din[0] = 4'h3;
    req[0] = 1'b1;
    tick();  // edge N samples req
    chk("t2_vld_n", 32'(vld[0]), 32'd0);
    tick();
    chk("t2_vld_n1", 32'(vld[0]), 32'd0);
    tick();
    chk("t2_cap_n2", {vld[0], dout[0], ack[0], serr[0]}, {28'd0, 1'b1, 4'h3, 1'b0, 1'b0});
    tick();
    chk("t2_ack_n3", {vld[0], ack[0]}, 32'b01);
    req[0] = 1'b0;
    tick();
    chk("t2_ack_m", 32'(ack[0]), 32'd1);
    tick();
    chk("t2_ack_m1", 32'(ack[0]), 32'd1);
    tick();
    chk("t2_ack_m2", {ack[0], busy[0]}, 32'd0);

    // T3: 0..F then wrap to 0, all in sequence
    reset_dut(0, 2);
    vld_tot[0] = 0; err_tot[0] = 0;
    for (int i = 0; i < 17; i++) begin
      w = 4'(i);
      xfer(0, w, 1'b0, "t3");
    end
    chk("t3_vld_total", 32'(vld_tot[0]), 32'd17);
    chk("t3_err_cnt", 32'(ecnt[0]), 32'd0);

    // T4: 5,7,8 -> only 7 breaks the sequence
    reset_dut(0, 2);
    xfer(0, 4'h5, 1'b0, "t4_w5");
    xfer(0, 4'h7, 1'b1, "t4_w7");
    xfer(0, 4'h8, 1'b0, "t4_w8");
    chk("t4_err_cnt", 32'(ecnt[0]), 32'd1);

    // T5: reset while in ACK with req still high
    reset_dut(0, 2);
    din[0] = 4'h6;
    req[0] = 1'b1;
    t = 0;
    while (!ack[0] && t < 40) begin tick(); t++; end
    chk("t5_in_ack", 32'(ack[0]), 32'd1);
    rst[0] = 1'b1;
    tick();
    chk("t5_rst_outs", {ack[0], vld[0], dout[0], busy[0]}, 32'd0);
    rst[0] = 1'b0;
    xfer(0, 4'h6, 1'b0, "t5");

    // T6: ack delayed 4 cycles after vld, then saturating error count
    din[1] = 4'h0;
    req[1] = 1'b1;
    t = 0;
    while (!vld[1] && t < 40) begin tick(); t++; end
    chk("t6_vld", {vld[1], dout[1]}, {27'd0, 1'b1, 4'h0});
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t6_ack_wait", {ack[1], busy[1]}, 32'b01);
    end
    tick();
    chk("t6_ack_rise", 32'(ack[1]), 32'd1);
    req[1] = 1'b0;
    t = 0;
    while (ack[1] && t < 40) begin tick(); t++; end
    chk("t6_ack_fall", 32'(ack[1]), 32'd0);
    for (int i = 0; i < 300; i++) begin
      xfer(1, 4'h0, 1'b1, "t6_bad");
      if (i == 9) chk("t6_cnt10", 32'(ecnt[1]), 32'd10);
    end
    chk("t6_err_pulses", 32'(err_tot[1]), 32'd300);
    chk("t6_err_sat", 32'(ecnt[1]), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
